// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, drives the combinational instruction-memory address and
// registers the returned word, its PC and PC+4 into the IF/ID register.
// Optional feature macro: FETCH_PERF_EN adds saturating fetch/bubble counters;
// without it fetch_cnt and bubble_cnt are tied to zero.
//
// Flow control: valid_d=1 means IF/ID holds a real instruction, valid_d=0 a
// bubble. There is no ready signal; decode backpressure arrives as stall_d
// (hold IF/ID) and stall_f (hold PC), and flush_d discards the IF/ID word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [31:0]      pc_target_e,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        ifid_load;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;
  assign ifid_load  = !flush_d && !stall_d;

  // Next-PC select: redirect (word-aligned) beats stall, otherwise sequential.
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e) begin
      pc_next = {pc_target_e[31:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_f;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // IF/ID register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= imem_instr;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating counters of IF/ID loads and inserted bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ifid_load && (fetch_cnt != CNT_MAX)) begin
        fetch_cnt <= fetch_cnt + CNT_ONE;
      end
      if (flush_d && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end
`else
  logic unused_load;
  assign unused_load = ifid_load;
  assign fetch_cnt   = '0;
  assign bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/flush/redirect
// traffic, compared every cycle against a behavioural model of the IF stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'd0;
  logic [31:0] imem_instr, imem_addr, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_cnt, bubble_cnt;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_instr(imem_instr), .imem_addr(imem_addr), .pc_f(pc_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem [256];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stage contents as plain values: what the fetch PC is, and which
  // (word, pc, valid) the decode slot holds after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fcnt, m_bcnt;
  logic        m_valid;
  bit          model_ok = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) begin
    logic [31:0] fetched;
    if (rst) begin
      m_pc = 32'd0; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      m_fcnt = 0; m_bcnt = 0;
      model_ok = 1;
    end else if (model_ok) begin
      fetched = mem_word(m_pc);
      if (flush_d) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
      end else if (!stall_d) begin
        m_instr = fetched; m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
        if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      end
      if (pc_src_e)      m_pc = pc_target_e & ~32'd3;
      else if (!stall_f) m_pc = m_pc + 4;
    end
    exp_q.delete();
    exp_q.push_back(m_pc);
    exp_q.push_back(m_instr);
    exp_q.push_back(m_pcd);
    exp_q.push_back(m_pc4);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_ok && exp_q.size() == 4) begin
      check("pc_f",       pc_f,       exp_q[0]);
      check("imem_addr",  imem_addr,  exp_q[0]);
      check("instr_d",    instr_d,    exp_q[1]);
      check("pc_d",       pc_d,       exp_q[2]);
      check("pc_plus4_d", pc_plus4_d, exp_q[3]);
      check("valid_d",    {31'd0, valid_d}, {31'd0, m_valid});
`ifdef FETCH_PERF_EN
      check("fetch_cnt",  fetch_cnt,  m_fcnt);
      check("bubble_cnt", bubble_cnt, m_bcnt);
`else
      check("fetch_cnt",  fetch_cnt,  32'd0);
      check("bubble_cnt", bubble_cnt, 32'd0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic sf, input logic sd,
                      input logic fl, input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    #1;
    rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps; pc_target_e = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
    mem[16] = 32'h1616_1616;

    // 1: reset then free-run
    step(1, 0, 0, 0, 0, 32'd0);
    check("rst_pc_f", pc_f, 32'd0);
    check("rst_instr_d", instr_d, 32'h0000_0013);
    check("rst_valid_d", {31'd0, valid_d}, 32'd0);
    run(1);
    check("t1_pc_f_1", pc_f, 32'h4);
    check("t1_instr_A", instr_d, 32'hAAAA_0001);
    check("t1_valid", {31'd0, valid_d}, 32'd1);
    run(3);
    check("t1_pc_f_4", pc_f, 32'h10);
    check("t1_instr_D", instr_d, 32'hDDDD_0004);
    check("t1_pc_d_C", pc_d, 32'hC);

    // 2: stall both at pc_f=8, then release
    step(1, 0, 0, 0, 0, 32'd0);
    run(2);
    check("t2_pc_f_8", pc_f, 32'h8);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'd0);
    check("t2_hold_pc", pc_f, 32'h8);
    check("t2_hold_instr", instr_d, 32'hBBBB_0002);
    check("t2_hold_pc_d", pc_d, 32'h4);
    run(1);
    check("t2_resume_instr", instr_d, 32'hCCCC_0003);
    check("t2_resume_pc_d", pc_d, 32'h8);
    check("t2_resume_pc_f", pc_f, 32'hC);

    // 3: redirect + flush with stall_f
    step(0, 1, 0, 1, 1, 32'h40);
    check("t3_pc_f", pc_f, 32'h40);
    check("t3_bubble", instr_d, 32'h0000_0013);
    check("t3_valid", {31'd0, valid_d}, 32'd0);
    run(1);
    check("t3_target_word", instr_d, 32'h1616_1616);

    // 4: misaligned target
    step(0, 0, 0, 1, 1, 32'h23);
    check("t4_align", pc_f, 32'h20);

    // 5: wrap at top of address space
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    check("t5_top", pc_f, 32'hFFFF_FFFC);
    run(1);
    check("t5_wrap_pc_f", pc_f, 32'h0);
    check("t5_pc_d", pc_d, 32'hFFFF_FFFC);
    check("t5_pc_plus4_d", pc_plus4_d, 32'h0);

    // 6: reset during stall/flush, then 10 loads + 2 flushes
    step(1, 1, 1, 1, 1, 32'h80);
    check("t6_rst_pc_f", pc_f, 32'h0);
    check("t6_rst_instr", instr_d, 32'h0000_0013);
    check("t6_rst_pc_d", pc_d, 32'h0);
    check("t6_rst_pc4", pc_plus4_d, 32'h0);
    check("t6_rst_valid", {31'd0, valid_d}, 32'd0);
    run(10);
    step(0, 0, 0, 1, 0, 32'd0);
    step(0, 0, 0, 1, 0, 32'd0);
`ifdef FETCH_PERF_EN
    check("t6_fetch_cnt", fetch_cnt, 32'd10);
    check("t6_bubble_cnt", bubble_cnt, 32'd2);
`else
    check("t6_fetch_cnt", fetch_cnt, 32'd0);
    check("t6_bubble_cnt", bubble_cnt, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, sf, sd, fl, ps;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (ps && $urandom_range(0, 1) == 1) fl = 1'b1;
      step(r, sf, sd, fl, ps, tgt);
    end
    step(0, 0, 0, 0, 0, 32'd0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
